// File: rtl/sap_ctrl_if.sv
// Control bundle between the SAP sequencer and the datapath: run/opcode in,
// one-hot T-state, status and active-high control strobes out.
interface sap_ctrl_if;
  logic       run;
  logic [3:0] opcode;
  logic       pc_inc;
  logic       pc_out;
  logic       mar_in;
  logic       ram_out;
  logic       ir_in;
  logic       ir_out;
  logic       a_in;
  logic       a_out;
  logic       b_in;
  logic       alu_sub;
  logic       alu_out;
  logic       out_in;
  logic [5:0] tstate;
  logic       halted;
  logic [7:0] instr_count;

  modport master (
    input  run, opcode,
    output pc_inc, pc_out, mar_in, ram_out, ir_in, ir_out, a_in, a_out,
           b_in, alu_sub, alu_out, out_in, tstate, halted, instr_count
  );

  modport slave (
    output run, opcode,
    input  pc_inc, pc_out, mar_in, ram_out, ir_in, ir_out, a_in, a_out,
           b_in, alu_sub, alu_out, out_in, tstate, halted, instr_count
  );
endinterface

// File: rtl/sap_controller_sequencer.sv
// SAP-1 style controller: six-step one-hot ring (T1..T6), opcode decode into
// control strobes, sticky halt, run/pause gate and a retired-instruction count.
module sap_controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic       clock,
  input  logic       reset,
  sap_ctrl_if.master bus
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  typedef struct packed {
    logic pc_inc;
    logic pc_out;
    logic mar_in;
    logic ram_out;
    logic ir_in;
    logic ir_out;
    logic a_in;
    logic a_out;
    logic b_in;
    logic alu_sub;
    logic alu_out;
    logic out_in;
  } strobes_t;

  tstate_e    tstate_q, tstate_d;
  logic       halted_q, halted_d;
  logic [7:0] count_q, count_d;
  logic       active;
  strobes_t   decode;
  strobes_t   strobes;

  assign active = bus.run & ~halted_q;

  // NOTE: synchronous reset, so it sits inside the clocked branch and is
  // sampled only on the rising edge; it also overrides run and halt.
  always_ff @(posedge clock) begin
    if (reset) begin
      tstate_q <= T1;
      halted_q <= 1'b0;
      count_q  <= 8'h00;
    end else begin
      tstate_q <= tstate_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  // NOTE: every next-state variable gets its hold value first so no path
  // through the case leaves one unassigned (which would infer a latch).
  always_comb begin
    tstate_d = tstate_q;
    halted_d = halted_q;
    count_d  = count_q;
    case (tstate_q)
      T1: if (active) tstate_d = T2;
      T2: if (active) tstate_d = T3;
      T3: if (active) tstate_d = T4;
      T4: begin
        if (active) begin
          if (bus.opcode == OP_HLT) halted_d = 1'b1;
          else                      tstate_d = T5;
        end
      end
      T5: if (active) tstate_d = T6;
      T6: begin
        if (active) begin
          tstate_d = T1;
          count_d  = count_q + 8'd1;
        end
      end
      // Corrupted ring state resynchronises to fetch regardless of run.
      default: tstate_d = T1;
    endcase
  end

  always_comb begin
    decode = '0;
    case (tstate_q)
      T1: begin decode.pc_out  = 1'b1; decode.mar_in = 1'b1; end
      T2: decode.pc_inc = 1'b1;
      T3: begin decode.ram_out = 1'b1; decode.ir_in  = 1'b1; end
      T4: begin
        if (bus.opcode == OP_LDA || bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
          decode.ir_out = 1'b1;
          decode.mar_in = 1'b1;
        end else if (bus.opcode == OP_OUT) begin
          decode.a_out  = 1'b1;
          decode.out_in = 1'b1;
        end
      end
      T5: begin
        if (bus.opcode == OP_LDA) begin
          decode.ram_out = 1'b1;
          decode.a_in    = 1'b1;
        end else if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
          decode.ram_out = 1'b1;
          decode.b_in    = 1'b1;
        end
      end
      T6: begin
        if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
          decode.alu_out = 1'b1;
          decode.a_in    = 1'b1;
          decode.alu_sub = (bus.opcode == OP_SUB);
        end
      end
      default: decode = '0;
    endcase
  end

  assign strobes = active ? decode : '0;

  assign bus.pc_inc      = strobes.pc_inc;
  assign bus.pc_out      = strobes.pc_out;
  assign bus.mar_in      = strobes.mar_in;
  assign bus.ram_out     = strobes.ram_out;
  assign bus.ir_in       = strobes.ir_in;
  assign bus.ir_out      = strobes.ir_out;
  assign bus.a_in        = strobes.a_in;
  assign bus.a_out       = strobes.a_out;
  assign bus.b_in        = strobes.b_in;
  assign bus.alu_sub     = strobes.alu_sub;
  assign bus.alu_out     = strobes.alu_out;
  assign bus.out_in      = strobes.out_in;
  assign bus.tstate      = tstate_q;
  assign bus.halted      = halted_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Bench for sap_controller_sequencer: step-number reference model built from
// the fetch/execute tables, directed scenarios plus randomized run/opcode.
module tb_sap_controller_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sap_ctrl_if tif ();

  sap_controller_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (tif)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  bit mon_en       = 1'b0;

  // Reference model: step 0..5 stands for T1..T6.
  int         m_step   = 0;
  bit         m_halted = 1'b0;
  logic [7:0] m_count  = 8'h00;

  localparam int PC_INC = 11, PC_OUT = 10, MAR_IN = 9, RAM_OUT = 8, IR_IN = 7,
                 IR_OUT = 6, A_IN = 5, A_OUT = 4, B_IN = 3, ALU_SUB = 2,
                 ALU_OUT = 1, OUT_IN = 0;

  function automatic logic [11:0] exp_strobes(int step, logic [3:0] op, logic run, bit halted);
    logic [11:0] s;
    s = '0;
    if (!run || halted) return s;
    case (step)
      0: begin s[PC_OUT] = 1'b1; s[MAR_IN] = 1'b1; end
      1: s[PC_INC] = 1'b1;
      2: begin s[RAM_OUT] = 1'b1; s[IR_IN] = 1'b1; end
      3: begin
        if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin s[IR_OUT] = 1'b1; s[MAR_IN] = 1'b1; end
        if (op == 4'hE) begin s[A_OUT] = 1'b1; s[OUT_IN] = 1'b1; end
      end
      4: begin
        if (op == 4'h0) begin s[RAM_OUT] = 1'b1; s[A_IN] = 1'b1; end
        if (op == 4'h1 || op == 4'h2) begin s[RAM_OUT] = 1'b1; s[B_IN] = 1'b1; end
      end
      5: begin
        if (op == 4'h1 || op == 4'h2) begin s[ALU_OUT] = 1'b1; s[A_IN] = 1'b1; end
        if (op == 4'h2) s[ALU_SUB] = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic logic [11:0] obs_strobes();
    return {tif.pc_inc, tif.pc_out, tif.mar_in, tif.ram_out, tif.ir_in, tif.ir_out,
            tif.a_in, tif.a_out, tif.b_in, tif.alu_sub, tif.alu_out, tif.out_in};
  endfunction

  function automatic logic [26:0] obs_vec();
    return {tif.tstate, tif.halted, tif.instr_count, obs_strobes()};
  endfunction

  function automatic logic [26:0] exp_vec();
    logic [5:0] t;
    t = 6'(1 << m_step);
    return {t, m_halted, m_count, exp_strobes(m_step, tif.opcode, tif.run, m_halted)};
  endfunction

  task automatic drive(input logic r, input logic [3:0] op, input logic rs);
    reset      = rs;
    tif.run    = r;
    tif.opcode = op;
    #1;
  endtask

  // One rising edge; the model applies the rules with the inputs seen there.
  task automatic tick();
    @(posedge clock);
    if (reset) begin
      m_step = 0; m_halted = 1'b0; m_count = 8'h00;
    end else if (tif.run && !m_halted) begin
      if (m_step == 3 && tif.opcode == 4'hF) m_halted = 1'b1;
      else if (m_step == 5) begin m_step = 0; m_count = m_count + 8'd1; end
      else m_step = m_step + 1;
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    drive(1'b0, 4'h0, 1'b1);
    tick();
    drive(1'b0, 4'h0, 1'b0);
  endtask

  // Invariants checked mid-low-phase every cycle, after inputs have settled.
  always @(negedge clock) begin
    if (mon_en) begin
      #2;
      tests_run++;
      if (!$onehot(tif.tstate)) begin
        tests_failed++;
        $display("FAIL onehot: tstate=%b", tif.tstate);
      end
      tests_run++;
      if ($countones({tif.pc_out, tif.ram_out, tif.ir_out, tif.a_out, tif.alu_out}) > 1) begin
        tests_failed++;
        $display("FAIL bus_drivers: strobes=%b, at most one driver required", obs_strobes());
      end
      tests_run++;
      if ((!tif.run || tif.halted) && obs_strobes() !== 12'h000) begin
        tests_failed++;
        $display("FAIL gated: strobes=%b with run=%b halted=%b, required 0", obs_strobes(), tif.run, tif.halted);
      end
    end
  end

  task automatic test_reset();
    drive(1'b1, 4'hF, 1'b1);
    tick();
    drive(1'b0, 4'h0, 1'b0);
    mon_en = 1'b1;
    tests_run++;
    if ({tif.tstate, tif.halted, tif.instr_count, obs_strobes()} !== {6'b000001, 1'b0, 8'h00, 12'h000}) begin
      tests_failed++;
      $display("FAIL reset: got %h required %h", obs_vec(),
               {6'b000001, 1'b0, 8'h00, 12'h000});
    end
  endtask

  task automatic test_lda_walk();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'h0, 1'b0);
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL lda_walk step %0d: got %h required %h", i, obs_vec(), exp_vec());
      end
      tick();
    end
    drive(1'b1, 4'h0, 1'b0);
    tests_run++;
    if (tif.tstate !== 6'b000001 || tif.instr_count !== 8'd1) begin
      tests_failed++;
      $display("FAIL lda_retire: tstate=%b count=%0d required 000001/1", tif.tstate, tif.instr_count);
    end
  endtask

  task automatic test_sub();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'h2, 1'b0);
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL sub step %0d: got %h required %h", i, obs_vec(), exp_vec());
      end
      tests_run++;
      if (tif.alu_sub !== (i == 5) || tif.b_in !== (i == 4)) begin
        tests_failed++;
        $display("FAIL sub_sel step %0d: alu_sub=%b b_in=%b", i, tif.alu_sub, tif.b_in);
      end
      tick();
    end
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, 4'hF, 1'b0);
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL halt cycle %0d: got %h required %h", i, obs_vec(), exp_vec());
      end
      tick();
    end
    tests_run++;
    if (tif.halted !== 1'b1 || tif.tstate !== 6'b001000 || tif.instr_count !== 8'h00) begin
      tests_failed++;
      $display("FAIL halt_hold: halted=%b tstate=%b count=%0d required 1/001000/0",
               tif.halted, tif.tstate, tif.instr_count);
    end
  endtask

  task automatic test_pause();
    int pc_inc_cycles;
    pc_inc_cycles = 0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive((i >= 2 && i <= 4) ? 1'b0 : 1'b1, 4'h1, 1'b0);
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL pause cycle %0d: got %h required %h", i, obs_vec(), exp_vec());
      end
      if (tif.pc_inc === 1'b1) pc_inc_cycles++;
      tick();
    end
    tests_run++;
    if (pc_inc_cycles != 1) begin
      tests_failed++;
      $display("FAIL pause_pc_inc: pc_inc high for %0d cycles, required 1", pc_inc_cycles);
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic       r;
    logic       rs;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 39))
        0:       op = 4'hF;
        1, 2, 3: op = 4'($urandom_range(3, 13));
        default: op = (($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 2)));
      endcase
      r  = ($urandom_range(0, 9) != 0);
      rs = (m_halted && $urandom_range(0, 5) == 0) || ($urandom_range(0, 199) == 0);
      drive(r, op, rs);
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL random cycle %0d: got %h required %h (run=%b op=%h)", i, obs_vec(), exp_vec(), r, op);
      end
      tick();
    end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    for (int i = 0; i < 256 * 6; i++) begin
      drive(1'b1, 4'h0, 1'b0);
      tick();
    end
    drive(1'b1, 4'h0, 1'b0);
    tests_run++;
    if (tif.instr_count !== 8'h00 || tif.tstate !== 6'b000001) begin
      tests_failed++;
      $display("FAIL wrap: count=%h tstate=%b required 00/000001", tif.instr_count, tif.tstate);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'h0, 1'b0);
      tick();
    end
    drive(1'b1, 4'h0, 1'b0);
    tests_run++;
    if (tif.tstate !== 6'b010000 || tif.instr_count !== 8'h00) begin
      tests_failed++;
      $display("FAIL pre_reset: tstate=%b count=%h required 010000/00", tif.tstate, tif.instr_count);
    end
    drive(1'b1, 4'h0, 1'b1);
    tick();
    drive(1'b1, 4'h0, 1'b0);
    tests_run++;
    if (tif.tstate !== 6'b000001 || tif.instr_count !== 8'h00 || tif.halted !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: tstate=%b count=%h halted=%b required 000001/00/0",
               tif.tstate, tif.instr_count, tif.halted);
    end
  endtask

  initial begin
    tif.run    = 1'b0;
    tif.opcode = 4'h0;
    @(negedge clock);
    test_reset();
    test_lda_walk();
    test_sub();
    test_halt();
    test_pause();
    test_random();
    test_wrap_and_reset();
    mon_en = 1'b0;
    #20;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
